approx_sub12u_pipe: RTL and testbench
=====================================

Name: approx_sub12u_pipe

Overview:
- Pipelined, handshaked approximate unsigned subtractor; the inverse-direction companion of the approximate 12-bit adders in the approximate-arithmetic library.
- Computes D = A − B with the low APPROX_BITS result bits approximated by copying A (no borrow generated or propagated there).
- Upper bits are exact, split over two register stages.
- Used wherever datapaths need the difference counterpart of the approximate adders under a streaming valid/ready interface.

Parameters:
- WIDTH, 12, operand width.
- APPROX_BITS, 4, number of low result bits taken directly from A; borrow-in to bit APPROX_BITS is forced 0.
- SPLIT, 8, pipeline cut bit index.
  - Stage 1 computes bits [APPROX_BITS, SPLIT).
  - Stage 2 computes bits [SPLIT, WIDTH).
  - Legal range: 0 <= APPROX_BITS < SPLIT < WIDTH; violations are an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  minuend.
- in_b  in  WIDTH  subtrahend.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_diff  out  WIDTH  approximate difference.
- out_borrow  out  1  borrow out of MSB; {out_borrow, out_diff} is the 13-bit two's-complement result.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - Reset is synchronous and active-low (rst_n).
  - While rst_n=0 at a clk edge: both stage-valid flags clear, out_valid=0, out_diff=0, out_borrow=0, all data registers clear.
  - in_ready=1 in the first cycle after reset release.
  - Reset mid-operation discards in-flight data silently.
- Arithmetic:
  - diff[APPROX_BITS-1:0] = A[APPROX_BITS-1:0].
  - {borrow, diff[WIDTH-1:APPROX_BITS]} = A[hi] − B[hi] with borrow-in 0.
  - Consequence: approx − exact = B[APPROX_BITS-1:0] exactly, always ≥ 0, worst-case error = 2^APPROX_BITS − 1 (15 at defaults).
- Pipeline:
  - Stage 1 registers the A/B upper slices above SPLIT, the slice [APPROX_BITS, SPLIT) result, its borrow, and A's low bits.
  - Stage 2 registers the full result and final borrow; stage 2 is the output register.
  - Latency: 2 cycles from input handshake to out_valid with no backpressure.
  - Throughput: 1 result per cycle.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready. in_ready must not depend combinationally on in_valid.
  - A stage holds data and valid while its downstream is stalled. out_diff/out_borrow are stable while out_valid && !out_ready.
  - Simultaneous input accept and output drain at full occupancy: both occur in the same cycle with no bubble and no loss.
  - Empty pipeline: out_valid=0; out_diff holds its last value (don't-care to consumers).
- Boundary cases:
  - A=B: result 0 in the upper part, low bits = A_lo, borrow 0.
  - A_hi < B_hi: borrow=1, diff wraps modulo 2^WIDTH.
  - in_b=all ones or in_a=0: no special-casing.
  - APPROX_BITS=0: block is an exact 2-stage subtractor.

Optional Feature:
- Macro: APPROX_SUB_ERRMON_EN.
- When defined:
  - B[APPROX_BITS-1:0] is carried down the pipeline alongside the data.
  - Extra outputs:
    - err_max (APPROX_BITS bits): running maximum of per-result error, updated on each output transfer.
    - err_cnt (16 bits): count of output transfers with nonzero error, saturating at 0xFFFF.
  - Both reset to 0 on rst_n=0.
- When undefined: the ports, registers and logic are absent; datapath timing is identical.

Decomposition:
- Package approx_sub_pkg holds:
  - default WIDTH/APPROX_BITS/SPLIT constants;
  - a parameter-legality check function;
  - the error-monitor counter width constant (16).
- One sub-module: approx_sub_slice.
  - Combinational borrow-ripple slice (parameter W).
  - Inputs a, b, bin; outputs d, bout.
  - Instantiated once per stage.

Test Plan:
- Reset, then in_a=0x123, in_b=0x045, out_ready=1 -> out_valid asserted exactly 2 cycles after accept; out_diff=0x0E3, out_borrow=0 (exact 0x0DE, error 5).
- in_a=0x010, in_b=0x020 -> out_diff=0xFF0, out_borrow=1 ({borrow,diff}=0x1FF0=−16, exact); then in_a=0x005, in_b=0x003 -> out_diff=0x005, borrow 0.
- Stream 8 back-to-back operands with out_ready=1 -> 8 results on consecutive cycles, in order, in_ready stays 1.
- Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts, out_diff stable; release -> no loss or duplication, order preserved.
- Random 10k operand pairs vs. reference model; assert (approx − exact) mod 2^13 == B[3:0] -> max observed error 15 (WCE).
- Assert rst_n=0 with both stages full -> next cycle out_valid=0, out_diff=0, in_ready=1. With APPROX_SUB_ERRMON_EN: err_max=0 and err_cnt=0 after reset; after the first test, err_max=5, err_cnt=1.

Source files
------------

// File: rtl/approx_sub_pkg.sv
// Shared constants and parameter-legality check for the approximate subtractor.
// The error monitor is enabled by defining APPROX_SUB_ERRMON_EN.
package approx_sub_pkg;

    localparam int DEF_WIDTH       = 12;
    localparam int DEF_APPROX_BITS = 4;
    localparam int DEF_SPLIT       = 8;
    localparam int ERR_CNT_W       = 16;

    function automatic bit params_legal(input int width, input int approx_bits, input int split);
        return (approx_bits >= 0) && (approx_bits < split) && (split < width);
    endfunction

endpackage

// File: rtl/approx_sub_slice.sv
// Combinational borrow-ripple subtractor slice: {bout, d} = a - b - bin.
module approx_sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic brw;

    // NOTE: blocking assignments here model the ripple within one evaluation;
    // every output gets a default first so no latch is inferred.
    always_comb begin
        d   = '0;
        brw = bin;
        for (int i = 0; i < W; i++) begin
            d[i] = a[i] ^ b[i] ^ brw;
            brw  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
        end
        bout = brw;
    end

endmodule

// File: rtl/approx_sub12u_pipe.sv
// Two-stage valid/ready approximate subtractor: low APPROX_BITS copied from A,
// upper bits exact. Optional error monitor via `define APPROX_SUB_ERRMON_EN.
module approx_sub12u_pipe
    import approx_sub_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS,
    parameter int SPLIT       = DEF_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow
`ifdef APPROX_SUB_ERRMON_EN
   ,output logic [((APPROX_BITS > 0) ? APPROX_BITS : 1)-1:0] err_max,
    output logic [ERR_CNT_W-1:0]                            err_cnt
`endif
);

    localparam int LO_W = (APPROX_BITS > 0) ? APPROX_BITS : 1;
    localparam int M_W  = SPLIT - APPROX_BITS;
    localparam int H_W  = WIDTH - SPLIT;

    if (!params_legal(WIDTH, APPROX_BITS, SPLIT)) begin : g_param_check
        $error("approx_sub12u_pipe: need 0 <= APPROX_BITS < SPLIT < WIDTH");
    end

    logic            s1_valid;
    logic [H_W-1:0]  s1_a_hi;
    logic [H_W-1:0]  s1_b_hi;
    logic [M_W-1:0]  s1_d_mid;
    logic            s1_borrow;
    logic [LO_W-1:0] s1_a_lo;

    logic [M_W-1:0]   mid_d;
    logic             mid_bout;
    logic [H_W-1:0]   hi_d;
    logic             hi_bout;
    logic [WIDTH-1:0] s2_diff_next;
    logic             s2_advance;

    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    // Borrow-in to the exact region is forced to zero; low bits never borrow.
    approx_sub_slice #(.W(M_W)) u_slice_mid (
        .a    (in_a[SPLIT-1:APPROX_BITS]),
        .b    (in_b[SPLIT-1:APPROX_BITS]),
        .bin  (1'b0),
        .d    (mid_d),
        .bout (mid_bout)
    );

    approx_sub_slice #(.W(H_W)) u_slice_hi (
        .a    (s1_a_hi),
        .b    (s1_b_hi),
        .bin  (s1_borrow),
        .d    (hi_d),
        .bout (hi_bout)
    );

    if (APPROX_BITS > 0) begin : g_lo
        assign s2_diff_next = {hi_d, s1_d_mid, s1_a_lo};
    end else begin : g_exact
        assign s2_diff_next = {hi_d, s1_d_mid};
    end

    // NOTE: sequential state uses non-blocking assignments only; data registers
    // are cleared by reset too, so outputs read 0 straight after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a_hi    <= '0;
            s1_b_hi    <= '0;
            s1_d_mid   <= '0;
            s1_borrow  <= 1'b0;
            s1_a_lo    <= '0;
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_a_hi   <= in_a[WIDTH-1:SPLIT];
                s1_b_hi   <= in_b[WIDTH-1:SPLIT];
                s1_d_mid  <= mid_d;
                s1_borrow <= mid_bout;
                s1_a_lo   <= in_a[LO_W-1:0];
            end
            if (s2_advance) begin
                out_valid <= s1_valid;
            end
            if (s1_valid && s2_advance) begin
                out_diff   <= s2_diff_next;
                out_borrow <= hi_bout;
            end
        end
    end

`ifdef APPROX_SUB_ERRMON_EN
    // The per-result error equals B's discarded low bits, so carry them along.
    logic [LO_W-1:0] s1_b_lo;
    logic [LO_W-1:0] s2_b_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_b_lo <= '0;
            s2_b_lo <= '0;
            err_max <= '0;
            err_cnt <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_b_lo <= in_b[LO_W-1:0];
            end
            if (s1_valid && s2_advance) begin
                s2_b_lo <= s1_b_lo;
            end
            if (out_valid && out_ready) begin
                if (s2_b_lo > err_max) begin
                    err_max <= s2_b_lo;
                end
                if ((s2_b_lo != '0) && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_approx_sub12u_pipe.sv
// Self-checking bench for approx_sub12u_pipe: directed vectors, a queue-based
// arithmetic model, streaming, backpressure, random soak and mid-flight reset.
module tb_approx_sub12u_pipe;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a;
    logic [11:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_diff;
    logic        out_borrow;
`ifdef APPROX_SUB_ERRMON_EN
    logic [3:0]  err_max;
    logic [15:0] err_cnt;
    logic [3:0]  m_err_max;
    logic [15:0] m_err_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int in_fires = 0;
    int stall_cnt = 0;
    int cyc = 0;
    int max_err = 0;
    op_t exp_q[$];
    int  out_cyc[$];
    bit  prev_hold = 0;
    logic [12:0] prev_data;

    approx_sub12u_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_diff   (out_diff),
        .out_borrow (out_borrow)
`ifdef APPROX_SUB_ERRMON_EN
       ,.err_max    (err_max),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upper part is a plain difference of A/16 and B/16; low nibble is A's.
    function automatic logic [12:0] model(input logic [11:0] a, input logic [11:0] b);
        int hi;
        int r;
        hi = int'(a >> 4) - int'(b >> 4);
        r  = hi * 16 + int'(a & 12'hF);
        return r[12:0];
    endfunction

    // Compare process: scoreboard, hold stability, error property, monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 0;
`ifdef APPROX_SUB_ERRMON_EN
            m_err_max = '0;
            m_err_cnt = '0;
`endif
        end else begin
`ifdef APPROX_SUB_ERRMON_EN
            check("err_max", err_max, m_err_max);
            check("err_cnt", err_cnt, m_err_cnt);
`endif
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_borrow, out_diff}, prev_data);
            end
            if (out_valid && out_ready) begin
                check("out_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    op_t op;
                    int  exact;
                    int  err;
                    op = exp_q.pop_front();
                    check("result", {out_borrow, out_diff}, model(op.a, op.b));
                    exact = (int'(op.a) - int'(op.b)) & 8191;
                    err   = (int'({out_borrow, out_diff}) - exact) & 8191;
                    check("err_is_b_lo", err, op.b & 12'hF);
                    if (err > max_err) max_err = err;
`ifdef APPROX_SUB_ERRMON_EN
                    if (op.b[3:0] > m_err_max) m_err_max = op.b[3:0];
                    if (op.b[3:0] != 0 && m_err_cnt != 16'hFFFF) m_err_cnt++;
`endif
                end
                out_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{a: in_a, b: in_b});
                in_fires++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = {out_borrow, out_diff};
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [11:0] a, input logic [11:0] b);
        bit ok = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            stall_cnt++;
        end
        check("in_ready_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain", (exp_q.size() != 0) || out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int acc0;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;

        // Model pins
        check("model_0x123_0x045", model(12'h123, 12'h045), 13'h00E3);
        check("model_0x010_0x020", model(12'h010, 12'h020), 13'h1FF0);
        check("model_0x005_0x003", model(12'h005, 12'h003), 13'h0005);
        check("model_a_eq_b", model(12'h7A5, 12'h7A5), 13'h0005);
        check("model_0_minus_fff", model(12'h000, 12'hFFF), 13'h1010);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_diff", out_diff, 0);
        check("rst_out_borrow", out_borrow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // First transaction: latency and value
        send(12'h123, 12'h045);
        @(negedge clk);
        check("lat_cycle1_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_out_valid", out_valid, 1);
        check("first_result", {out_borrow, out_diff}, 13'h00E3);
        wait_drain();
`ifdef APPROX_SUB_ERRMON_EN
        check("errmon_first_max", err_max, 5);
        check("errmon_first_cnt", err_cnt, 1);
`endif

        // Borrow, small, equal and extreme operands
        send(12'h010, 12'h020);
        send(12'h005, 12'h003);
        send(12'h7A5, 12'h7A5);
        send(12'h000, 12'hFFF);
        send(12'hFFF, 12'h000);
        wait_drain();

        // Back-to-back stream
        out_cyc.delete();
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send(12'(i * 12'h1F3 + 12'h0A7), 12'(i * 12'h095 + 12'h011));
        check("stream_in_ready_held", stall_cnt, 0);
        wait_drain();
        check("stream_out_count", out_cyc.size(), 8);
        if (out_cyc.size() == 8) check("stream_out_consecutive", out_cyc[7] - out_cyc[0], 7);

        // Backpressure
        out_ready = 1'b0;
        acc0 = in_fires;
        fork
            for (int i = 0; i < 6; i++) send(12'(12'h800 + i * 12'h111), 12'(12'h03C + i * 12'h021));
        join_none
        repeat (5) @(negedge clk);
        #1;
        check("stall_accepts", in_fires - acc0, 2);
        check("stall_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait fork;
        wait_drain();
        check("stall_total_accepts", in_fires - acc0, 6);

        // Random soak with random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 10000; i++) send(12'($urandom), 12'($urandom));
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("max_err_wce", max_err, 15);

        // Reset with both stages full
        out_ready = 1'b0;
        send(12'h456, 12'h123);
        send(12'h789, 12'h321);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_diff", out_diff, 0);
        check("midrst_out_borrow", out_borrow, 0);
        check("midrst_in_ready", in_ready, 1);
`ifdef APPROX_SUB_ERRMON_EN
        check("midrst_err_max", err_max, 0);
        check("midrst_err_cnt", err_cnt, 0);
`endif
        @(posedge clk);
        #1;
        send(12'hABC, 12'h0AB);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
